// File: rtl/io_periph_bus.sv
// Memory-mapped IO peripheral: LED register, debounced switch capture with a
// valid flag, and an 8-digit 7-segment display with a ready/acknowledge handshake.

module io_periph_debounce #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_raw,
   output logic pulse
);
   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_HI, HELD, WAIT_LO} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sync1_q, sync2_q;
   logic            armed_q, armed_d;

   // Synchronisers reset to "pressed" so a button held through reset must be
   // seen released (arming) before a new press is accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      pulse   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!sync2_q) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = WAIT_HI;
               cnt_d   = '0;
            end
         end
         WAIT_HI: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               pulse   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               state_d = WAIT_LO;
               cnt_d   = '0;
            end
         end
         WAIT_LO: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
endmodule

module io_periph_bus #(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned SCAN_DIV   = 100_000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  io_addr,
   input  logic [31:0] io_dout,
   input  logic        io_we,
   input  logic        io_rd,
   output logic [31:0] io_din,
   input  logic [15:0] sw,
   input  logic        btn_in,
   input  logic        btn_ack,
   output logic [15:0] led,
   output logic [7:0]  an,
   output logic [6:0]  seg
);
   localparam logic [7:0] A_LED     = 8'h00;
   localparam logic [7:0] A_IN_VLD  = 8'h04;
   localparam logic [7:0] A_IN_DATA = 8'h08;
   localparam logic [7:0] A_OUT_RDY = 8'h0C;
   localparam logic [7:0] A_OUT     = 8'h10;

   localparam int unsigned SW_ = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW_-1:0] SCAN_LAST = SW_'(SCAN_DIV - 1);

   logic [15:0]    led_q, led_d;
   logic [15:0]    in_data_q, in_data_d;
   logic           in_vld_q, in_vld_d;
   logic [31:0]    out_data_q, out_data_d;
   logic           out_rdy_q, out_rdy_d;
   logic [SW_-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]     digit_q, digit_d;
   logic           in_pulse, ack_pulse;
   logic [3:0]     nib;
   logic [6:0]     glyph;

   io_periph_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_in (
      .clk     (clk),
      .rstn    (rstn),
      .btn_raw (btn_in),
      .pulse   (in_pulse)
   );

   io_periph_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ack (
      .clk     (clk),
      .rstn    (rstn),
      .btn_raw (btn_ack),
      .pulse   (ack_pulse)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         led_q      <= '0;
         in_data_q  <= '0;
         in_vld_q   <= 1'b0;
         out_data_q <= '0;
         out_rdy_q  <= 1'b1;
         scan_cnt_q <= '0;
         digit_q    <= '0;
      end else begin
         led_q      <= led_d;
         in_data_q  <= in_data_d;
         in_vld_q   <= in_vld_d;
         out_data_q <= out_data_d;
         out_rdy_q  <= out_rdy_d;
         scan_cnt_q <= scan_cnt_d;
         digit_q    <= digit_d;
      end
   end

   always_comb begin
      led_d      = led_q;
      in_data_d  = in_data_q;
      in_vld_d   = in_vld_q;
      out_data_d = out_data_q;
      out_rdy_d  = out_rdy_q;
      scan_cnt_d = scan_cnt_q;
      digit_d    = digit_q;

      if (io_we && io_addr == A_LED) led_d = io_dout[15:0];

      // Capture beats a same-cycle clear only when the flag was empty.
      if (in_pulse && !in_vld_q) begin
         in_data_d = sw;
         in_vld_d  = 1'b1;
      end else if (io_rd && io_addr == A_IN_DATA) begin
         in_vld_d = 1'b0;
      end

      if (io_we && io_addr == A_OUT) begin
         out_data_d = io_dout;
         out_rdy_d  = 1'b0;
      end else if (ack_pulse) begin
         out_rdy_d = 1'b1;
      end

      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         digit_d    = digit_q + 3'd1;
      end else begin
         scan_cnt_d = scan_cnt_q + 1'b1;
      end
   end

   always_comb begin
      io_din = '0;
      case (io_addr)
         A_IN_VLD:  io_din = {31'b0, in_vld_q};
         A_IN_DATA: io_din = {16'b0, in_data_q};
         A_OUT_RDY: io_din = {31'b0, out_rdy_q};
         default:   io_din = '0;
      endcase
   end

   always_comb begin
      nib = out_data_q[{digit_q, 2'b00} +: 4];
      case (nib)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
      // Display is blanked combinationally while reset is asserted.
      an  = rstn ? ~(8'b0000_0001 << digit_q) : 8'hFF;
      seg = rstn ? ~glyph : 7'h7F;
   end

   assign led = led_q;
endmodule

// File: tb/tb_io_periph_bus.sv
// Self-checking bench for io_periph_bus: reference model compared every cycle
// plus directed scenarios with literal expectations.

module tb_io_periph_bus;
   localparam int unsigned DEB  = 8;
   localparam int unsigned SCAN = 4;

   logic        clk  = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  io_addr = 8'h0C;
   logic [31:0] io_dout = '0;
   logic        io_we = 1'b0;
   logic        io_rd = 1'b0;
   logic [31:0] io_din;
   logic [15:0] sw = '0;
   logic        btn_in = 1'b0;
   logic        btn_ack = 1'b0;
   logic [15:0] led;
   logic [7:0]  an;
   logic [6:0]  seg;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   io_periph_bus #(.DEB_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
      .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout),
      .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .sw(sw),
      .btn_in(btn_in), .btn_ack(btn_ack), .led(led), .an(an), .seg(seg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Active-low segment patterns, bit0 = a ... bit6 = g.
   function automatic logic [6:0] seg_of(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
         4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
         4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
         4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   // Reference model
   logic [15:0] m_led = '0, m_in_data = '0;
   logic        m_in_vld = 1'b0, m_out_rdy = 1'b1;
   logic [31:0] m_out_data = '0;
   int          m_digit = 0, m_scan = 0;
   bit          m_s1[2], m_s2[2], m_acc[2], m_armed[2], m_p[2], m_raw[2];
   int          m_run[2];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_led = '0; m_in_data = '0; m_in_vld = 1'b0;
         m_out_data = '0; m_out_rdy = 1'b1; m_digit = 0; m_scan = 0;
         for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1; m_s2[b] = 1; m_acc[b] = 0; m_armed[b] = 0; m_run[b] = 0;
         end
      end else begin
         m_raw[0] = btn_in;
         m_raw[1] = btn_ack;
         for (int b = 0; b < 2; b++) begin
            m_p[b] = 0;
            if (!m_armed[b]) begin
               if (!m_s2[b]) m_armed[b] = 1;
            end else if (m_s2[b] != m_acc[b]) begin
               m_run[b]++;
               if (m_run[b] == DEB + 1) begin
                  m_acc[b] = m_s2[b];
                  m_run[b] = 0;
                  m_p[b]   = m_s2[b];
               end
            end else begin
               m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = m_raw[b];
         end
         if (io_we && io_addr == 8'h00) m_led = io_dout[15:0];
         if (m_p[0] && !m_in_vld) begin
            m_in_data = sw; m_in_vld = 1'b1;
         end else if (io_rd && io_addr == 8'h08) begin
            m_in_vld = 1'b0;
         end
         if (io_we && io_addr == 8'h10) begin
            m_out_data = io_dout; m_out_rdy = 1'b0;
         end else if (m_p[1]) begin
            m_out_rdy = 1'b1;
         end
         m_scan++;
         if (m_scan == SCAN) begin
            m_scan  = 0;
            m_digit = (m_digit + 1) % 8;
         end
      end
   end

   function automatic logic [31:0] m_din(input logic [7:0] a);
      case (a)
         8'h04:   return {31'b0, m_in_vld};
         8'h08:   return {16'b0, m_in_data};
         8'h0C:   return {31'b0, m_out_rdy};
         default: return '0;
      endcase
   endfunction

   always @(negedge clk) begin
      check("m_led", {16'b0, led}, {16'b0, m_led});
      check("m_io_din", io_din, m_din(io_addr));
      check("m_an", {24'b0, an}, rstn ? {24'b0, ~(8'h01 << m_digit)} : 32'hFF);
      check("m_seg", {25'b0, seg}, rstn ? {25'b0, seg_of(m_out_data[4*m_digit +: 4])} : 32'h7F);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      io_addr = a; io_dout = d; io_we = 1'b1;
      tick();
      io_we = 1'b0;
   endtask

   task automatic peek(input string name, input logic [7:0] a, input logic [31:0] exp, input bit clr);
      io_addr = a; io_rd = clr;
      @(negedge clk);
      check(name, io_din, exp);
      tick();
      io_rd = 1'b0;
   endtask

   task automatic press_in(input int hold);
      btn_in = 1'b1;
      repeat (hold) tick();
      btn_in = 1'b0;
      repeat (DEB + 6) tick();
   endtask

   task automatic press_ack(input int hold);
      btn_ack = 1'b1;
      repeat (hold) tick();
      btn_ack = 1'b0;
      repeat (DEB + 6) tick();
   endtask

   task automatic wait_digit(input string name, input logic [7:0] an_v, input logic [6:0] seg_v);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (an == an_v) break;
      end
      check({name, "_an"}, {24'b0, an}, {24'b0, an_v});
      check({name, "_seg"}, {25'b0, seg}, {25'b0, seg_v});
      tick();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an", {24'b0, an}, 32'hFF);
      check("rst_seg", {25'b0, seg}, 32'h7F);
      check("rst_rdy", io_din, 32'h1);
      #1 rstn = 1'b1;
      tick();

      // LED write, write-only register reads zero
      wr(8'h00, 32'h0001_A5C3);
      io_addr = 8'h00;
      @(negedge clk);
      check("led_wr", {16'b0, led}, 32'h0000_A5C3);
      check("led_rd0", io_din, 32'h0);
      tick();

      // Capture, dropped second capture, read-clear, short bounce
      sw = 16'h1234;
      press_in(DEB + 4);
      peek("in_vld1", 8'h04, 32'h1, 0);
      sw = 16'hFFFF;
      press_in(DEB + 4);
      peek("in_keep", 8'h08, 32'h0000_1234, 0);
      peek("in_rd", 8'h08, 32'h0000_1234, 1);
      peek("in_clr", 8'h04, 32'h0, 0);
      press_in(4);
      peek("bounce", 8'h04, 32'h0, 0);

      // Display write, acknowledge, scan glyphs
      wr(8'h10, 32'hDEAD_BEEF);
      peek("rdy0", 8'h0C, 32'h0, 0);
      press_ack(DEB + 4);
      peek("rdy1", 8'h0C, 32'h1, 0);
      wait_digit("dig0", 8'hFE, 7'h0E);
      wait_digit("dig7", 8'h7F, 7'h21);

      // Write of 0x10 coincident with the ack pulse: write wins
      btn_ack = 1'b1;
      repeat (DEB + 2) tick();
      wr(8'h10, 32'h0123_4567);
      repeat (4) tick();
      btn_ack = 1'b0;
      repeat (DEB + 6) tick();
      peek("wr_ack", 8'h0C, 32'h0, 0);

      // Read of 0x08 coincident with the capture pulse while empty: capture wins
      sw = 16'hABCD;
      btn_in = 1'b1;
      repeat (DEB + 2) tick();
      peek("rd_cap_old", 8'h08, 32'h0000_1234, 1);
      peek("rd_cap_vld", 8'h04, 32'h1, 0);
      peek("rd_cap_dat", 8'h08, 32'h0000_ABCD, 0);
      btn_in = 1'b0;
      repeat (DEB + 6) tick();

      // Reset mid-debounce and mid-scan with the button still held
      peek("pre_rst_clr", 8'h08, 32'h0000_ABCD, 1);
      wr(8'h00, 32'h0000_FFFF);
      sw = 16'h5555;
      btn_in = 1'b1;
      io_addr = 8'h0C;
      repeat (5) tick();
      #2 rstn = 1'b0;
      @(negedge clk);
      check("mid_rst_led", {16'b0, led}, 32'h0);
      check("mid_rst_an", {24'b0, an}, 32'hFF);
      check("mid_rst_seg", {25'b0, seg}, 32'h7F);
      check("mid_rst_rdy", io_din, 32'h1);
      repeat (3) tick();
      rstn = 1'b1;
      repeat (3 * DEB) tick();
      peek("held_no_pulse", 8'h04, 32'h0, 0);
      btn_in = 1'b0;
      repeat (DEB + 6) tick();
      peek("release_no_pulse", 8'h04, 32'h0, 0);
      sw = 16'h0F0F;
      press_in(DEB + 4);
      peek("repress_vld", 8'h04, 32'h1, 0);
      peek("repress_dat", 8'h08, 32'h0000_0F0F, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
